// File: rtl/fp_wb_scoreboard_if.sv
// Write-back request channel from one FP producer.
// The producer holds valid/rd/data stable until it sees ready.
interface fp_wb_scoreboard_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic [4:0]        rd;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );
endinterface

// File: rtl/fp_wb_scoreboard.sv
// FP register-file write-back arbiter with busy scoreboard.
// Drives the single write port and the decode-stage hazard stall.
module fp_wb_scoreboard #(
  parameter int DATA_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        chk_rs1,
  input  logic [4:0]        chk_rs2,
  input  logic [4:0]        chk_rd,
  input  logic              chk_uses_rd,
  output logic              stall,
  fp_wb_scoreboard_if.slave alu,
  fp_wb_scoreboard_if.slave div,
  output logic              regWr,
  output logic [4:0]        rW,
  output logic [DATA_W-1:0] busW,
  output logic [31:0]       busy_vec
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_DIV = 1'b1
  } grant_e;

  grant_e            last_grant;
  logic              alu_gnt;
  logic              div_gnt;
  logic              wb_fire;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       busy;
  logic [31:0]       busy_nxt;

  always_comb begin
    alu_gnt = 1'b0;
    div_gnt = 1'b0;
    unique case (1'b1)
      (alu.valid && !div.valid): alu_gnt = 1'b1;
      (div.valid && !alu.valid): div_gnt = 1'b1;
      (alu.valid && div.valid): begin
        if (RR_EN && last_grant == GNT_ALU)
          div_gnt = 1'b1;
        else
          alu_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu.ready = alu_gnt;
  assign div.ready = div_gnt;
  assign wb_fire   = alu_gnt | div_gnt;
  assign wb_rd     = div_gnt ? div.rd : alu.rd;
  assign wb_data   = div_gnt ? div.data : alu.data;

  // Clear lands on the commit edge; a same-edge issue re-owns the reg.
  always_comb begin
    busy_nxt = busy;
    if (regWr)
      busy_nxt[rW] = 1'b0;
    if (iss_valid && iss_rd != 5'd0)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign stall = busy[chk_rs1]
               | busy[chk_rs2]
               | (chk_uses_rd & busy[chk_rd]);

  assign busy_vec = busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      regWr      <= 1'b0;
      rW         <= 5'd0;
      busW       <= '0;
      busy       <= 32'd0;
      last_grant <= GNT_DIV;
    end else begin
      regWr <= wb_fire && (wb_rd != 5'd0);
      busy  <= busy_nxt;
      if (wb_fire) begin
        rW         <= wb_rd;
        busW       <= wb_data;
        last_grant <= div_gnt ? GNT_DIV : GNT_ALU;
      end
    end
  end

endmodule

// File: tb/tb_fp_wb_scoreboard.sv
// Scoreboard bench: round-robin and fixed-priority instances
// share stimulus and are checked against a queue-based model.
module tb_fp_wb_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        chk_uses_rd;

  logic        stall_a, stall_b;
  logic        regWr_a, regWr_b;
  logic [4:0]  rW_a, rW_b;
  logic [63:0] busW_a, busW_b;
  logic [31:0] busy_a, busy_b;

  fp_wb_scoreboard_if #(.DATA_W(64)) alu_a ();
  fp_wb_scoreboard_if #(.DATA_W(64)) div_a ();
  fp_wb_scoreboard_if #(.DATA_W(64)) alu_b ();
  fp_wb_scoreboard_if #(.DATA_W(64)) div_b ();

  assign alu_b.valid = alu_a.valid;
  assign alu_b.rd    = alu_a.rd;
  assign alu_b.data  = alu_a.data;
  assign div_b.valid = div_a.valid;
  assign div_b.rd    = div_a.rd;
  assign div_b.data  = div_a.data;

  fp_wb_scoreboard #(.DATA_W(64), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_rd(chk_rd), .chk_uses_rd(chk_uses_rd),
    .stall(stall_a), .alu(alu_a), .div(div_a),
    .regWr(regWr_a), .rW(rW_a), .busW(busW_a),
    .busy_vec(busy_a)
  );

  fp_wb_scoreboard #(.DATA_W(64), .RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_rd(chk_rd), .chk_uses_rd(chk_uses_rd),
    .stall(stall_b), .alu(alu_b), .div(div_b),
    .regWr(regWr_b), .rW(rW_b), .busW(busW_b),
    .busy_vec(busy_b)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  bit    alu_fire = 1'b0;
  bit    div_fire = 1'b0;
  bit    [31:0] busy_m = '0;
  bit    pref_div = 1'b0;
  wr_t   exp_q[$];
  bit    fp_pend = 1'b0;
  wr_t   fp_exp;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model state advances here to what the next edge should produce.
  always @(negedge clk) begin : mon
    wr_t  w;
    bit   commit;
    logic [4:0] commit_rd;
    bit   e_alu, e_div;
    if (mon_en) begin
      commit = 1'b0;
      commit_rd = 5'd0;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        commit = 1'b1;
        commit_rd = w.rd;
        check("rr_regWr", {63'd0, regWr_a}, 64'd1);
        if (regWr_a) begin
          check("rr_rW", {59'd0, rW_a}, {59'd0, w.rd});
          check("rr_busW", busW_a, w.data);
        end
      end else begin
        check("rr_regWr_idle", {63'd0, regWr_a}, 64'd0);
      end

      if (fp_pend) begin
        check("fp_regWr", {63'd0, regWr_b}, 64'd1);
        check("fp_rW", {59'd0, rW_b}, {59'd0, fp_exp.rd});
        check("fp_busW", busW_b, fp_exp.data);
      end else begin
        check("fp_regWr_idle", {63'd0, regWr_b}, 64'd0);
      end

      check("busy_vec", {32'd0, busy_a}, {32'd0, busy_m});
      check("stall", {63'd0, stall_a},
            {63'd0, busy_m[chk_rs1] | busy_m[chk_rs2]
                    | (chk_uses_rd & busy_m[chk_rd])});

      e_alu = alu_a.valid && (!div_a.valid || !pref_div);
      e_div = div_a.valid && !e_alu;
      check("rr_alu_ready", {63'd0, alu_a.ready}, {63'd0, e_alu});
      check("rr_div_ready", {63'd0, div_a.ready}, {63'd0, e_div});
      check("fp_alu_ready", {63'd0, alu_b.ready},
            {63'd0, alu_a.valid});
      check("fp_div_ready", {63'd0, div_b.ready},
            {63'd0, div_a.valid && !alu_a.valid});

      alu_fire = alu_a.valid && alu_a.ready;
      div_fire = div_a.valid && div_a.ready;

      if (!reset) begin
        busy_m   = '0;
        pref_div = 1'b0;
        fp_pend  = 1'b0;
      end else begin
        if (commit)
          busy_m[commit_rd] = 1'b0;
        if (iss_valid)
          busy_m[iss_rd] = 1'b1;
        busy_m[0] = 1'b0;
        if (e_alu) begin
          if (alu_a.rd != 5'd0)
            exp_q.push_back('{alu_a.rd, alu_a.data});
          pref_div = 1'b1;
        end else if (e_div) begin
          if (div_a.rd != 5'd0)
            exp_q.push_back('{div_a.rd, div_a.data});
          pref_div = 1'b0;
        end
        fp_pend = 1'b0;
        if (alu_a.valid) begin
          fp_pend = (alu_a.rd != 5'd0);
          fp_exp  = '{alu_a.rd, alu_a.data};
        end else if (div_a.valid) begin
          fp_pend = (div_a.rd != 5'd0);
          fp_exp  = '{div_a.rd, div_a.data};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    alu_a.valid = 1'b0;
    div_a.valid = 1'b0;
    iss_valid   = 1'b0;
    chk_rs1     = 5'd0;
    chk_rs2     = 5'd0;
    chk_rd      = 5'd0;
    chk_uses_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    alu_a.valid = 1'b1; alu_a.rd = 5'd3; alu_a.data = 64'h1111;
    div_a.valid = 1'b1; div_a.rd = 5'd7; div_a.data = 64'h7777;
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    mon_en = 1'b1;
    tick();
    iss_valid = 1'b0;
    reset = 1'b1;
    repeat (4) tick();
    idle_all();
    tick();

    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; chk_rs1 = 5'd5;
    alu_a.valid = 1'b1; alu_a.rd = 5'd5;
    alu_a.data = 64'h4000000000000000;
    tick();
    alu_a.valid = 1'b0;
    repeat (2) tick();
    idle_all();

    iss_valid = 1'b1; iss_rd = 5'd0;
    div_a.valid = 1'b1; div_a.rd = 5'd0; div_a.data = 64'hdead;
    chk_rs2 = 5'd0;
    tick();
    idle_all();
    tick();

    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    div_a.valid = 1'b1; div_a.rd = 5'd9;
    div_a.data = {$urandom, $urandom};
    tick();
    div_a.valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0; chk_rs1 = 5'd9;
    repeat (2) tick();
    idle_all();

    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    iss_valid = 1'b0; chk_uses_rd = 1'b1; chk_rd = 5'd12;
    tick();
    alu_a.valid = 1'b1; alu_a.rd = 5'd12;
    alu_a.data = {$urandom, $urandom};
    tick();
    alu_a.valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    idle_all();
    tick();

    repeat (3000) begin
      if (!alu_a.valid || alu_fire) begin
        alu_a.valid = ($urandom_range(0, 9) < 6);
        alu_a.rd    = 5'($urandom);
        alu_a.data  = {$urandom, $urandom};
      end
      if (!div_a.valid || div_fire) begin
        div_a.valid = ($urandom_range(0, 9) < 4);
        div_a.rd    = 5'($urandom);
        div_a.data  = {$urandom, $urandom};
      end
      iss_valid   = ($urandom_range(0, 2) == 0);
      iss_rd      = 5'($urandom);
      chk_rs1     = 5'($urandom);
      chk_rs2     = 5'($urandom);
      chk_rd      = 5'($urandom);
      chk_uses_rd = 1'($urandom);
      reset       = ($urandom_range(0, 199) != 0);
      tick();
    end

    reset = 1'b1;
    idle_all();
    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
